// File: rtl/upcount_if.sv
// upcount_if: control and status bundle for the loadable up-counter.
// The wraps field exists only when UPCOUNT_WRAPCNT_EN is defined.
interface upcount_if #(parameter int n = 8);
    logic [n-1:0] r;
    logic [n-1:0] limit;
    logic [n-1:0] q;
    logic l;
    logic e;
    logic mode;
    logic tc;
    logic busy;
    logic done;
`ifdef UPCOUNT_WRAPCNT_EN
    logic [7:0] wraps;
    modport master (output r, l, e, limit, mode, input q, tc, busy, done, wraps);
    modport slave (input r, l, e, limit, mode, output q, tc, busy, done, wraps);
`else
    modport master (output r, l, e, limit, mode, input q, tc, busy, done);
    modport slave (input r, l, e, limit, mode, output q, tc, busy, done);
`endif
endinterface

// File: rtl/upcount_mod.sv
// upcount_mod: loadable up-counter to a programmable limit, wrap or one-shot, with terminal-count pulse.
// Defining UPCOUNT_WRAPCNT_EN adds a saturating count of terminal steps on bus.wraps.
module upcount_mod #(parameter int n = 8) (
    input logic clk,
    input logic rst,
    upcount_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    state_t state, state_nx;
    logic [n-1:0] q, q_nx;
    logic tc, term;
    // Load outranks counting, so a load edge is never a terminal step
    always_comb begin
        term = state == COUNT && !bus.l && bus.e && q == bus.limit;
        state_nx = bus.l ? COUNT : (term && bus.mode) ? DONE : state;
        q_nx = bus.l ? bus.r : term ? (bus.mode ? q : '0) : (state == COUNT && bus.e) ? q + 1'b1 : q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q <= '0;
            tc <= 1'b0;
        end else begin
            state <= state_nx;
            q <= q_nx;
            tc <= term;
        end
    end
    assign bus.q = q;
    assign bus.tc = tc;
    assign bus.busy = state == COUNT;
    assign bus.done = state == DONE;
`ifdef UPCOUNT_WRAPCNT_EN
    logic [7:0] wraps;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wraps <= '0;
        else wraps <= bus.l ? '0 : (term && wraps != 8'hff) ? wraps + 1'b1 : wraps;
    end
    assign bus.wraps = wraps;
`endif
endmodule
